adc_spi_capture: RTL and testbench

Front end of the audio path. Drives a 12-bit serial ADC (ADCS7476-class, 16-clock frame: 4 leading zeros then 12 data bits MSB-first) at a fixed sample rate. Deserialises each conversion and presents it as a held 12-bit sample with a one-cycle strobe. Its `adc_data` output feeds the `sample_in` input of `framing` inside `top_ap`.

---
 rtl/ap_adc_pkg.sv | 7 +
 rtl/adc_sample_timer.sv | 30 +++
 rtl/adc_spi_capture.sv | 97 +++++++++
 tb/tb_adc_spi_capture.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/ap_adc_pkg.sv
// ap_adc_pkg: shared constants and FSM state type for the serial ADC capture front end.
package ap_adc_pkg;
    localparam int ADC_BITS   = 12;
    localparam int FRAME_BITS = 16;
    localparam int LEAD_ZEROS = 4;
    typedef enum logic [2:0] {IDLE, START, SHIFT, DONE, QUIET} adc_state_t;
endpackage

// File: rtl/adc_sample_timer.sv
// adc_sample_timer: sample-period counter producing one start tick per period while enabled.
module adc_sample_timer #(
    parameter int SAMPLE_PERIOD = 6250
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic idle,
    output logic tick
);
    localparam int W = $clog2(SAMPLE_PERIOD);
    localparam logic [W-1:0] LAST = W'(SAMPLE_PERIOD - 1);
    logic [W-1:0] timer;
    logic         wrap_q;
    assign tick = enable && timer == '0 && idle;
    // A busy FSM parks the timer at 0 so the first tick after enable rises waits for IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer  <= '0;
            wrap_q <= 1'b0;
        end else begin
            timer  <= (!enable || timer == LAST || (timer == '0 && !idle)) ? '0 : timer + 1'b1;
            wrap_q <= enable && timer == LAST;
        end
    end
    always @(posedge clk) begin
        if (!rst && wrap_q && enable)
            assert (idle);
    end
endmodule

// File: rtl/adc_spi_capture.sv
// adc_spi_capture: drives a 16-clock serial ADC frame at a fixed rate and presents each
// 12-bit conversion as a held sample with a one-cycle valid strobe.
module adc_spi_capture
    import ap_adc_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 6250,
    parameter int QUIET_CYCLES  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                miso,
    output logic                cs_n,
    output logic                sclk,
    output logic [ADC_BITS-1:0] adc_data,
    output logic                sample_valid,
    output logic                frame_err
);
    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] Q_LAST   = 16'(QUIET_CYCLES - 1);
    localparam logic [3:0]  BIT_LAST = 4'(FRAME_BITS - 1);

    if (SAMPLE_PERIOD < 33 * CLK_DIV + QUIET_CYCLES + 3 || CLK_DIV < 1 || QUIET_CYCLES < 1) begin : g_param_check
        $error("adc_spi_capture: SAMPLE_PERIOD too short for CLK_DIV/QUIET_CYCLES");
    end

    adc_state_t            state;
    logic [15:0]           cnt;
    logic [3:0]            bit_cnt;
    logic [FRAME_BITS-1:0] shift;
    logic                  miso_q;
    logic                  tick;

    adc_sample_timer #(.SAMPLE_PERIOD(SAMPLE_PERIOD)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .idle   (state == IDLE),
        .tick   (tick)
    );

    // Capture happens on the cycle that raises sclk, using the miso sample from the low phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cs_n         <= 1'b1;
            sclk         <= 1'b1;
            adc_data     <= '0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
            shift        <= '0;
            cnt          <= '0;
            bit_cnt      <= '0;
            miso_q       <= 1'b0;
        end else begin
            miso_q       <= miso;
            sample_valid <= 1'b0;
            case (state)
                IDLE: if (tick) begin
                    state <= START;
                    cs_n  <= 1'b0;
                    cnt   <= '0;
                end
                START: if (cnt == DIV_LAST) begin
                    state   <= SHIFT;
                    sclk    <= 1'b0;
                    cnt     <= '0;
                    bit_cnt <= '0;
                end else cnt <= cnt + 1'b1;
                SHIFT: if (cnt != DIV_LAST) cnt <= cnt + 1'b1;
                else begin
                    cnt <= '0;
                    if (!sclk) begin
                        sclk  <= 1'b1;
                        shift <= {shift[FRAME_BITS-2:0], miso_q};
                    end else if (bit_cnt == BIT_LAST) state <= DONE;
                    else begin
                        sclk    <= 1'b0;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DONE: begin
                    adc_data     <= shift[ADC_BITS-1:0];
                    frame_err    <= |shift[FRAME_BITS-1 -: LEAD_ZEROS];
                    sample_valid <= 1'b1;
                    cs_n         <= 1'b1;
                    cnt          <= '0;
                    state        <= QUIET;
                end
                QUIET: if (cnt == Q_LAST) state <= IDLE;
                else cnt <= cnt + 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_spi_capture.sv
// tb_adc_spi_capture: directed bench with serial ADC models and sample scoreboards for a
// default-parameter instance and a minimum-period CLK_DIV=1 instance.
module tb_adc_spi_capture;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, rst_b = 1'b1, enable = 1'b0, enable_b = 1'b0, miso = 1'b0, miso_b = 1'b0;
    logic        cs_n, sclk, sample_valid, frame_err;
    logic        cs_n_b, sclk_b, sample_valid_b, frame_err_b;
    logic [11:0] adc_data, adc_data_b;

    adc_spi_capture dut (
        .clk(clk), .rst(rst), .enable(enable), .miso(miso), .cs_n(cs_n), .sclk(sclk),
        .adc_data(adc_data), .sample_valid(sample_valid), .frame_err(frame_err)
    );
    adc_spi_capture #(.CLK_DIV(1), .SAMPLE_PERIOD(40), .QUIET_CYCLES(4)) dut_b (
        .clk(clk), .rst(rst_b), .enable(enable_b), .miso(miso_b), .cs_n(cs_n_b), .sclk(sclk_b),
        .adc_data(adc_data_b), .sample_valid(sample_valid_b), .frame_err(frame_err_b)
    );

    int checks = 0, errors = 0, cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] expect_of(input logic [15:0] w);
        return {|w[15:12], w[11:0]};
    endfunction

    logic [15:0] words_a[$], words_b[$];
    logic [12:0] exp_a[$], exp_b[$];
    task automatic push_a(input logic [15:0] w);
        words_a.push_back(w);
        exp_a.push_back(expect_of(w));
    endtask
    task automatic push_b(input logic [15:0] w);
        words_b.push_back(w);
        exp_b.push_back(expect_of(w));
    endtask

    // ADC models: present the frame MSB first, next bit after each sclk rise.
    logic [15:0] word_a, word_b;
    int idx_a, cur_a, rises_a, lo_a, fall_a, falls_a, vld_a, vcyc_a;
    int idx_b, cur_b, rises_b, lo_b, fall_b, vld_b, vcyc_b;
    logic [31:0] e_a, e_b;

    always @(negedge cs_n) begin
        word_a = 16'h0;
        if (words_a.size() != 0) word_a = words_a.pop_front();
        idx_a = 15; miso = word_a[15]; fall_a = cyc; cur_a = 0; falls_a++;
    end
    always @(posedge sclk) if (!cs_n) begin
        cur_a++; idx_a--;
        miso = (idx_a >= 0) ? word_a[idx_a] : 1'b0;
    end
    always @(posedge cs_n) begin lo_a = cyc - fall_a; rises_a = cur_a; end

    always @(negedge cs_n_b) begin
        word_b = 16'h0;
        if (words_b.size() != 0) word_b = words_b.pop_front();
        idx_b = 15; miso_b = word_b[15]; fall_b = cyc; cur_b = 0;
    end
    always @(posedge sclk_b) if (!cs_n_b) begin
        cur_b++; idx_b--;
        miso_b = (idx_b >= 0) ? word_b[idx_b] : 1'b0;
    end
    always @(posedge cs_n_b) begin lo_b = cyc - fall_b; rises_b = cur_b; end

    always @(negedge clk) if (sample_valid) begin
        vld_a++; vcyc_a = cyc;
        e_a = 32'hDEAD;
        if (exp_a.size() != 0) e_a = 32'(exp_a.pop_front());
        chk("a_sample", {19'd0, frame_err, adc_data}, e_a);
    end
    always @(negedge clk) if (sample_valid_b) begin
        vld_b++; vcyc_b = cyc;
        e_b = 32'hDEAD;
        if (exp_b.size() != 0) e_b = 32'(exp_b.pop_front());
        chk("b_sample", {19'd0, frame_err_b, adc_data_b}, e_b);
    end

    task automatic wait_vld(input bit b, input int n, input int budget);
        int k = 0;
        while ((b ? vld_b : vld_a) < n && k < budget) begin @(posedge clk); k++; end
        chk(b ? "b_valid_timeout" : "a_valid_timeout", 32'(k < budget), 1);
    endtask

    task automatic wait_bits_a(input int n, input int budget);
        int k = 0;
        while (!(cs_n == 1'b0 && cur_a >= n) && k < budget) begin @(posedge clk); k++; end
        chk("a_bit_timeout", 32'(k < budget), 1);
    endtask

    int t0, prev, f;
    initial begin
        repeat (3) @(negedge clk);
        chk("rst_cs_n", cs_n, 1);
        chk("rst_sclk", sclk, 1);
        chk("rst_adc_data", adc_data, 0);
        chk("rst_valid", sample_valid, 0);
        chk("rst_frame_err", frame_err, 0);
        rst = 1'b0;
        @(negedge clk);
        push_a(16'h0ABC);
        enable = 1'b1;
        t0 = cyc;
        wait_vld(0, 1, 200);
        chk("a_latency", vcyc_a - t0, 134);
        chk("a_cs_low", lo_a, 133);
        chk("a_sclk_rises", rises_a, 16);
        push_a(16'h8FFF);
        push_a(16'h0001);
        push_a(16'h0123);
        for (int i = 2; i <= 4; i++) begin
            prev = vcyc_a;
            wait_vld(0, i, 7000);
            chk("a_spacing", vcyc_a - prev, 6250);
            chk("a_cs_low", lo_a, 133);
            chk("a_sclk_rises", rises_a, 16);
        end
        push_a(16'h0555);
        wait_bits_a(5, 7000);
        @(negedge clk);
        enable = 1'b0;
        wait_vld(0, 5, 400);
        f = falls_a;
        repeat (7000) @(posedge clk);
        chk("drop_no_cs_activity", falls_a, f);
        chk("drop_no_valid", vld_a, 5);
        chk("drop_hold_data", adc_data, 12'h555);
        chk("drop_cs_n_high", cs_n, 1);
        push_a(16'h0777);
        @(negedge clk);
        enable = 1'b1;
        wait_bits_a(8, 400);
        while (sclk !== 1'b0) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_cs_n", cs_n, 1);
        chk("midrst_sclk", sclk, 1);
        chk("midrst_adc_data", adc_data, 0);
        chk("midrst_valid", sample_valid, 0);
        chk("midrst_frame_err", frame_err, 0);
        void'(exp_a.pop_back());
        push_a(16'h0246);
        @(negedge clk);
        rst = 1'b0;
        wait_vld(0, 6, 300);
        chk("after_rst_valid_count", vld_a, 6);
        @(negedge clk);
        enable = 1'b0;
        rst_b = 1'b0;
        for (int i = 0; i < 6; i++) push_b(i == 3 ? 16'hA5A5 : {4'h0, 12'($urandom)});
        enable_b = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            prev = vcyc_b;
            wait_vld(1, i, 100);
            if (i > 1) chk("b_spacing", vcyc_b - prev, 40);
            chk("b_cs_low", lo_b, 34);
            chk("b_sclk_rises", rises_b, 16);
        end
        @(negedge clk);
        enable_b = 1'b0;
        repeat (100) @(posedge clk);
        chk("b_valid_count", vld_b, 6);
        chk("a_scoreboard_empty", exp_a.size(), 0);
        chk("b_scoreboard_empty", exp_b.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
